decode_stage: RTL and testbench
===============================

# decode_stage

RV32I instruction decode stage sitting directly upstream of the register file. Accepts fetched instructions over a valid/ready handshake and drives the register file read addresses. Holds the ID/EX pipeline register: decoded fields, sign-extended immediate and control bits. Because the register file read is registered, this register lines up cycle-for-cycle with the register file's `readData1`/`readData2`; the block also detects load-use hazards and accepts pipeline flushes.

## Interface
- `DATAWIDTH`, 32, width of PC and immediate
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `if_valid` in 1, fetch presents an instruction
- `if_ready` out 1, stage accepts this cycle
- `if_instr` in 32, instruction word
- `if_pc` in DATAWIDTH, instruction PC
- `flush` in 1, kill the instruction held in the stage register and the one being accepted
- `hz_load` in 1, EX-stage instruction is a load
- `hz_rd` in 5, destination of that load
- `readReg1`, `readReg2` out 5, register file read addresses
- `ex_valid` out 1, stage register holds a live instruction
- `ex_ready` in 1, EX consumes this cycle
- `ex_pc` out DATAWIDTH, PC of the held instruction
- `ex_imm` out DATAWIDTH, sign-extended immediate
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5, decoded register fields
- `ex_funct3` out 3, decoded `funct3`
- `ex_funct7b5` out 1, instruction bit 30
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_alu_src`, `ex_branch`, `ex_jump`, `ex_illegal` out 1 each, control bits

## Operation
- **Accept:** when `if_valid && if_ready`.
- **`if_ready`:** `(!ex_valid || ex_ready) && !hazard`.
- **Hazard:** `hz_load && hz_rd != 0 && ((uses_rs1 && rs1 == hz_rd) || (uses_rs2 && rs2 == hz_rd))`.
  - `uses_rs1`: all formats except U and J.
  - `uses_rs2`: R, S and B formats.
- **Read addresses:**
  - When `if_ready`, `readReg1`/`readReg2` equal `if_instr[19:15]`/`if_instr[24:20]`.
  - Otherwise they equal the held `ex_rs1`/`ex_rs2`, so the register file output remains consistent with the held instruction during a stall.
- **Next state:** evaluated in priority order.
  - `flush`: `ex_valid` goes to 0.
  - Accept: load the decoded instruction and set `ex_valid` to 1.
  - `ex_ready` with no accept: `ex_valid` goes to 0, which inserts a bubble. A hazard lands here.
  - Otherwise: hold.
- **Opcodes decoded:** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode sets `ex_illegal` and clears every control bit.
- **`ex_reg_write`:** forced to 0 when `rd == 0`.
- **Immediates:** all sign-extended from instruction bit 31 to DATAWIDTH.
  - I: `[31:20]`
  - S: `{[31:25],[11:7]}`
  - B: `{[31],[7],[30:25],[11:8],0}`
  - U: `{[31:12],12'b0}`
  - J: `{[31],[19:12],[20],[30:21],0}`
  - R-type: immediate is 0.
- **`ex_alu_src`:** 1 for OP-IMM, LOAD, STORE, LUI, AUIPC and JALR.

## Timing
- **Latency:** an instruction accepted on edge N appears on the `ex_*` outputs after edge N. `readData1`/`readData2` become valid after that same edge.
- **Throughput:** one instruction per cycle when there is no stall.
- **Reset:** `ex_valid` and every `ex_*` register go to 0.
  - This makes `readReg1`/`readReg2` 0 unless the fetch side is accepting.
  - `if_ready` is 1 after reset when there is no hazard.
- **Reset mid-operation:** the held instruction is dropped with no partial output.
- **Flush with accept in the same cycle:** the incoming instruction is consumed on the fetch side and discarded. Fetch is responsible for re-steering.
- **Stall:** while `ex_valid && !ex_ready`, all `ex_*` outputs are held stable.
- **Hazard:** one bubble per cycle while `hz_load` matches. The instruction stays on the fetch port because `if_ready` is 0.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants
  - immediate-format enum (I/S/B/U/J/R)
  - ID/EX control struct typedef
- One sub-module, `imm_gen`: combinational, takes the instruction and format and produces `ex_imm` data.
- Decode logic and the stage register remain in `decode_stage`.

## Test plan
- **Reset then `addi x5,x1,-3` (`0xFFD08293`):** on the next edge, `ex_valid`=1, `ex_rd`=5, `ex_rs1`=1, `ex_imm`=`0xFFFFFFFD`, `ex_reg_write`=1, `ex_alu_src`=1. `readReg1` was 1 in the accept cycle.
- **`sw x2,8(x3)` (`0x0021A423`):** `ex_imm`=8, `ex_rs1`=3, `ex_rs2`=2, `ex_mem_write`=1, `ex_reg_write`=0.
- **`lui x7,0x12345` (`0x123453B7`) with `ex_ready`=0 for 3 cycles:** `ex_imm`=`0x12345000` held. `readReg1`/`readReg2` hold the decoded fields; `if_ready`=0.
- **`hz_load`=1, `hz_rd`=5, incoming `add x6,x5,x2`:** `if_ready`=0 and `ex_valid`=0 next cycle. Drop `hz_load` and the instruction is accepted the following edge.
- **`flush` while `ex_valid`=1 and fetch is valid:** `ex_valid`=0 next cycle and no outputs issue.
- **Opcode `0x7F` and `addi x0,...`:** first gives `ex_illegal`=1 with all controls 0. Second gives `ex_reg_write`=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the ID/EX control bundle.
// Pure types and constants; no timing or backpressure of its own.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the format-specific immediate and sign-extends it to DATAWIDTH.
// Purely combinational, zero latency, no backpressure.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [31:7]          instr,
  input  imm_fmt_e             fmt,
  output logic [DATAWIDTH-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast carries bit 31 up when DATAWIDTH exceeds 32.
  assign imm = DATAWIDTH'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode + ID/EX register; result visible one edge after accept, aligned with registered RF reads.
// Stalls fetch while EX holds the register or a load-use hazard is seen; flush kills held and incoming.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [31:0]          if_instr,
  input  logic [DATAWIDTH-1:0] if_pc,
  input  logic                 flush,
  input  logic                 hz_load,
  input  logic [4:0]           hz_rd,
  output logic [4:0]           readReg1,
  output logic [4:0]           readReg2,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [DATAWIDTH-1:0] ex_pc,
  output logic [DATAWIDTH-1:0] ex_imm,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [2:0]           ex_funct3,
  output logic                 ex_funct7b5,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_alu_src,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output logic                 ex_illegal
);

  logic [6:0]           opcode;
  logic [4:0]           dec_rs1, dec_rs2, dec_rd;
  imm_fmt_e             dec_fmt;
  ctrl_t                dec_ctrl;
  logic [DATAWIDTH-1:0] dec_imm;
  logic                 uses_rs1, uses_rs2, hazard, accept;

  logic                 ex_valid_q, ex_valid_d;
  logic [DATAWIDTH-1:0] ex_pc_q, ex_pc_d;
  logic [DATAWIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]           ex_rs1_q, ex_rs1_d;
  logic [4:0]           ex_rs2_q, ex_rs2_d;
  logic [4:0]           ex_rd_q, ex_rd_d;
  logic [2:0]           ex_funct3_q, ex_funct3_d;
  logic                 ex_funct7b5_q, ex_funct7b5_d;
  ctrl_t                ex_ctrl_q, ex_ctrl_d;

  assign opcode  = if_instr[6:0];
  assign dec_rd  = if_instr[11:7];
  assign dec_rs1 = if_instr[19:15];
  assign dec_rs2 = if_instr[24:20];

  always_comb begin
    dec_ctrl = '0;
    dec_fmt  = FMT_R;
    case (opcode)
      OPC_LUI: begin
        dec_fmt = FMT_U; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        dec_fmt = FMT_U; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1;
      end
      OPC_JAL: begin
        dec_fmt = FMT_J; dec_ctrl.reg_write = 1'b1; dec_ctrl.jump = 1'b1;
      end
      OPC_JALR: begin
        dec_fmt = FMT_I; dec_ctrl.reg_write = 1'b1; dec_ctrl.jump = 1'b1;
        dec_ctrl.alu_src = 1'b1;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B; dec_ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        dec_fmt = FMT_I; dec_ctrl.reg_write = 1'b1; dec_ctrl.mem_read = 1'b1;
        dec_ctrl.alu_src = 1'b1;
      end
      OPC_STORE: begin
        dec_fmt = FMT_S; dec_ctrl.mem_write = 1'b1; dec_ctrl.alu_src = 1'b1;
      end
      OPC_OPIMM: begin
        dec_fmt = FMT_I; dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1;
      end
      OPC_OP: begin
        dec_fmt = FMT_R; dec_ctrl.reg_write = 1'b1;
      end
      default: begin
        dec_fmt = FMT_R; dec_ctrl.illegal = 1'b1;
      end
    endcase
    if (dec_rd == 5'd0) dec_ctrl.reg_write = 1'b0;
  end

  imm_gen #(.DATAWIDTH(DATAWIDTH)) u_imm_gen (
    .instr (if_instr[31:7]),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  // Unknown opcodes decode as R-format, so they conservatively stall on either source.
  assign uses_rs1 = (dec_fmt != FMT_U) && (dec_fmt != FMT_J);
  assign uses_rs2 = (dec_fmt == FMT_R) || (dec_fmt == FMT_S) || (dec_fmt == FMT_B);
  assign hazard   = hz_load && (hz_rd != 5'd0) &&
                    ((uses_rs1 && dec_rs1 == hz_rd) || (uses_rs2 && dec_rs2 == hz_rd));
  assign if_ready = (!ex_valid_q || ex_ready) && !hazard;
  assign accept   = if_valid && if_ready;

  // During a stall the RF re-reads the held sources so readData stays matched to ex_*.
  assign readReg1 = if_ready ? dec_rs1 : ex_rs1_q;
  assign readReg2 = if_ready ? dec_rs2 : ex_rs2_q;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    ex_ctrl_d     = ex_ctrl_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = if_pc;
      ex_imm_d      = dec_imm;
      ex_rs1_d      = dec_rs1;
      ex_rs2_d      = dec_rs2;
      ex_rd_d       = dec_rd;
      ex_funct3_d   = if_instr[14:12];
      ex_funct7b5_d = if_instr[30];
      ex_ctrl_d     = dec_ctrl;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_ctrl_q     <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7b5  = ex_funct7b5_q;
  assign ex_reg_write = ex_ctrl_q.reg_write;
  assign ex_mem_read  = ex_ctrl_q.mem_read;
  assign ex_mem_write = ex_ctrl_q.mem_write;
  assign ex_alu_src   = ex_ctrl_q.alu_src;
  assign ex_branch    = ex_ctrl_q.branch;
  assign ex_jump      = ex_ctrl_q.jump;
  assign ex_illegal   = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push hand-decoded results,
// a monitor pops and compares each instruction as it first appears on the ex_* side.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [6:0]  ctrl;  // reg_write, mem_read, mem_write, alu_src, branch, jump, illegal
  } exp_t;

  logic        clk, rst;
  logic        if_valid, if_ready, flush, hz_load, ex_valid, ex_ready;
  logic [31:0] if_instr, if_pc, ex_pc, ex_imm;
  logic [4:0]  hz_rd, readReg1, readReg2, ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_alu_src, ex_branch, ex_jump, ex_illegal;

  int   n_chk, n_fail;
  exp_t sb[$];
  exp_t mon_act, mon_exp;
  logic mon_seen;

  decode_stage #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .hz_load(hz_load), .hz_rd(hz_rd),
    .readReg1(readReg1), .readReg2(readReg2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [2:0] f3, input logic f7b5, input logic [6:0] ctrl);
    exp_t e;
    e = '{pc: pc, imm: imm, rs1: rs1, rs2: rs2, rd: rd, f3: f3, f7b5: f7b5, ctrl: ctrl};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction that must be accepted on the coming edge.
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    logic [31:0] w;
    w        = instr;
    if_valid = 1'b1;
    if_instr = w;
    if_pc    = pc;
    @(negedge clk);
    chk("accept_if_ready", {31'd0, if_ready}, 32'd1);
    chk("accept_readReg1", {27'd0, readReg1}, {27'd0, w[19:15]});
    chk("accept_readReg2", {27'd0, readReg2}, {27'd0, w[24:20]});
    sb.push_back(e);
    step();
    if_valid = 1'b0;
  endtask

  initial begin : monitor
    mon_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_seen = 1'b0;
      end else begin
        if (ex_valid && !mon_seen) begin
          mon_act = '{pc: ex_pc, imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd,
                      f3: ex_funct3, f7b5: ex_funct7b5,
                      ctrl: {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                             ex_branch, ex_jump, ex_illegal}};
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %h expected no instruction", mon_act);
          end else begin
            mon_exp = sb.pop_front();
            if (mon_act !== mon_exp) begin
              n_fail++;
              $display("FAIL sb_compare: got %h expected %h", mon_act, mon_exp);
            end
          end
          mon_seen = 1'b1;
        end
        if (!ex_valid || ex_ready) mon_seen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin : stim
    n_chk = 0; n_fail = 0;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    flush = 1'b0; hz_load = 1'b0; hz_rd = '0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_readReg1", {27'd0, readReg1}, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    step();

    // Back-to-back: addi x5,x1,-3 then sw x2,8(x3)
    offer(32'hFFD08293, 32'h100, mk(32'h100, 32'hFFFFFFFD, 5'd1, 5'd29, 5'd5, 3'd0, 1'b1, 7'b1001000));
    offer(32'h0021A423, 32'h104, mk(32'h104, 32'h8, 5'd3, 5'd2, 5'd8, 3'd2, 1'b0, 7'b0011000));

    // lui x7,0x12345 then EX stalls three cycles with the next instruction waiting
    offer(32'h123453B7, 32'h108, mk(32'h108, 32'h12345000, 5'd8, 5'd3, 5'd7, 3'd5, 1'b0, 7'b1001000));
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'hFFD08293; if_pc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("stall_ex_imm", ex_imm, 32'h12345000);
      chk("stall_if_ready", {31'd0, if_ready}, 32'd0);
      chk("stall_readReg1", {27'd0, readReg1}, 32'd8);
      chk("stall_readReg2", {27'd0, readReg2}, 32'd3);
      step();
    end
    ex_ready = 1'b1;
    offer(32'hFFD08293, 32'h10C, mk(32'h10C, 32'hFFFFFFFD, 5'd1, 5'd29, 5'd5, 3'd0, 1'b1, 7'b1001000));

    // Load-use: EX load writes x5, incoming add x6,x5,x2
    hz_load = 1'b1; hz_rd = 5'd5;
    if_valid = 1'b1; if_instr = 32'h00228333; if_pc = 32'h110;
    @(negedge clk);
    chk("hz_if_ready", {31'd0, if_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("hz_bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("hz_if_ready_2", {31'd0, if_ready}, 32'd0);
    step();
    hz_load = 1'b0;
    offer(32'h00228333, 32'h110, mk(32'h110, 32'h0, 5'd5, 5'd2, 5'd6, 3'd0, 1'b0, 7'b1000000));

    // Flush while add is held and fetch presents another instruction
    flush = 1'b1;
    if_valid = 1'b1; if_instr = 32'hFFD08293; if_pc = 32'h114;
    @(negedge clk);
    chk("flush_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    step();

    // Illegal opcode, addi x0, jal, beq, lw
    offer(32'h000000FF, 32'h200, mk(32'h200, 32'h0, 5'd0, 5'd0, 5'd1, 3'd0, 1'b0, 7'b0000001));
    offer(32'h00508013, 32'h204, mk(32'h204, 32'h5, 5'd1, 5'd5, 5'd0, 3'd0, 1'b0, 7'b0001000));
    offer(32'h008000EF, 32'h208, mk(32'h208, 32'h8, 5'd0, 5'd8, 5'd1, 3'd0, 1'b0, 7'b1000010));
    offer(32'hFE208EE3, 32'h20C, mk(32'h20C, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd29, 3'd0, 1'b1, 7'b0000100));
    offer(32'h0040A283, 32'h210, mk(32'h210, 32'h4, 5'd1, 5'd4, 5'd5, 3'd2, 1'b0, 7'b1101000));

    // Reset while lw is held
    if_instr = '0; ex_ready = 1'b0;
    @(negedge clk);
    chk("hold_ex_rd", {27'd0, ex_rd}, 32'd5);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("midrst_ex_imm", ex_imm, 32'd0);
    chk("midrst_ex_rd", {27'd0, ex_rd}, 32'd0);
    step();
    rst = 1'b0; ex_ready = 1'b1;
    repeat (3) step();
    chk("sb_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
